// File: rtl/vga_pkg.sv
// Shared 640x480@60 VGA timing constants, frame-buffer geometry and RGB332 layout.
// VGA_SCAN_TESTPAT_EN adds the colour-bar helper used by the optional test pattern.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] H_VISIBLE    = 10'd640;
  localparam logic [CNT_W-1:0] H_FRONT      = 10'd16;
  localparam logic [CNT_W-1:0] H_SYNC       = 10'd96;
  localparam logic [CNT_W-1:0] H_BACK       = 10'd48;
  localparam logic [CNT_W-1:0] H_TOTAL      = 10'd800;
  localparam logic [CNT_W-1:0] H_SYNC_START = H_VISIBLE + H_FRONT;
  localparam logic [CNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;

  localparam logic [CNT_W-1:0] V_VISIBLE    = 10'd480;
  localparam logic [CNT_W-1:0] V_FRONT      = 10'd10;
  localparam logic [CNT_W-1:0] V_SYNC       = 10'd2;
  localparam logic [CNT_W-1:0] V_BACK       = 10'd33;
  localparam logic [CNT_W-1:0] V_TOTAL      = 10'd525;
  localparam logic [CNT_W-1:0] V_SYNC_START = V_VISIBLE + V_FRONT;
  localparam logic [CNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

  localparam int FB_WIDTH  = 160;
  localparam int FB_HEIGHT = 120;
  localparam int PIPE_LAT  = 3;

  localparam int R_MSB = 7;
  localparam int R_LSB = 5;
  localparam int G_MSB = 4;
  localparam int G_LSB = 2;
  localparam int B_MSB = 1;
  localparam int B_LSB = 0;

  // Raw, active-high timing flags travelling down the pixel pipeline.
  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } sync_t;

`ifdef VGA_SCAN_TESTPAT_EN
  // 8 bars of 80 px; bar index replicated across the RGB332 byte.
  function automatic logic [7:0] bar_byte(input logic [CNT_W-1:0] x);
    logic [2:0] b;
    b = '0;
    for (int i = 1; i < 8; i++)
      if (x >= CNT_W'(i * 80)) b = 3'(i);
    return {b, b, b[2:1]};
  endfunction
`endif

endpackage

// File: rtl/vga_timing_gen.sv
// Stage-0 raster counters with raw sync/active flags, vblank and frame_start.
module vga_timing_gen
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output sync_t            sync,
  output logic             frame_start,
  output logic             vblank
);

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount <= '0;
      vcount <= '0;
    end else if (hcount == H_TOTAL - 10'd1) begin
      hcount <= '0;
      vcount <= (vcount == V_TOTAL - 10'd1) ? '0 : vcount + 10'd1;
    end else begin
      hcount <= hcount + 10'd1;
    end
  end

  always_comb begin
    sync.hs     = (hcount >= H_SYNC_START) && (hcount <= H_SYNC_END);
    sync.vs     = (vcount >= V_SYNC_START) && (vcount <= V_SYNC_END);
    sync.active = (hcount < H_VISIBLE) && (vcount < V_VISIBLE);
  end

  assign vblank      = (vcount >= V_VISIBLE);
  assign frame_start = (hcount == '0) && (vcount == V_VISIBLE);

endmodule

// File: rtl/vga_scan_reader.sv
// Scans a 160x120 RGB332 frame buffer out as 640x480 VGA, each pixel replicated 4x4.
// Define VGA_SCAN_TESTPAT_EN to let test_mode replace memory data with colour bars.
module vga_scan_reader #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 16,
  parameter int FB_WIDTH    = 160,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  output logic [2:0]            vga_r,
  output logic [2:0]            vga_g,
  output logic [1:0]            vga_b,
  output logic                  vga_blank_n,
  output logic                  vblank,
  output logic                  frame_start,
  input  logic                  test_mode
);
  import vga_pkg::*;

  localparam logic [CNT_W-1:0] ROW_MASK = CNT_W'((1 << SCALE_SHIFT) - 1);

  logic [CNT_W-1:0]      hcount, vcount;
  sync_t                 sync_raw;
  sync_t [PIPE_LAT-2:0]  sync_pipe;
  logic [ADDR_WIDTH-1:0] line_base;
  logic [DATA_WIDTH-1:0] pix, pix_src;

  vga_timing_gen u_timing (
    .clk         (clk),
    .rst         (rst),
    .hcount      (hcount),
    .vcount      (vcount),
    .sync        (sync_raw),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  // Advance one buffer row after the last screen line of each replicated group.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_base <= '0;
    end else if (hcount == H_TOTAL - 10'd1) begin
      if (vcount == V_TOTAL - 10'd1)
        line_base <= '0;
      else if (((vcount & ROW_MASK) == ROW_MASK) && (vcount < V_VISIBLE))
        line_base <= line_base + ADDR_WIDTH'(FB_WIDTH);
    end
  end

  // Stage 1: address only moves in the visible area, so blanking holds it.
  always_ff @(posedge clk) begin
    if (rst)
      addr_b <= '0;
    else if (sync_raw.active)
      addr_b <= line_base + ADDR_WIDTH'(hcount >> SCALE_SHIFT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe[0] <= sync_raw;
      for (int i = 1; i <= PIPE_LAT - 2; i++)
        sync_pipe[i] <= sync_pipe[i-1];
    end
  end

`ifdef VGA_SCAN_TESTPAT_EN
  logic [PIPE_LAT-2:0][CNT_W-1:0] hx_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      hx_pipe <= '0;
    end else begin
      hx_pipe[0] <= hcount;
      for (int i = 1; i <= PIPE_LAT - 2; i++)
        hx_pipe[i] <= hx_pipe[i-1];
    end
  end

  assign pix_src = test_mode ? DATA_WIDTH'(bar_byte(hx_pipe[PIPE_LAT-2])) : q_b;
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;
  assign pix_src          = q_b;
`endif

  // Stage 3: everything registered together so colour and syncs line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_blank_n <= 1'b0;
      pix         <= '0;
    end else begin
      vga_hs      <= ~sync_pipe[PIPE_LAT-2].hs;
      vga_vs      <= ~sync_pipe[PIPE_LAT-2].vs;
      vga_blank_n <= sync_pipe[PIPE_LAT-2].active;
      pix         <= sync_pipe[PIPE_LAT-2].active ? pix_src : '0;
    end
  end

  assign vga_r = pix[R_MSB:R_LSB];
  assign vga_g = pix[G_MSB:G_LSB];
  assign vga_b = pix[B_MSB:B_LSB];

endmodule

// File: tb/tb_vga_scan_reader.sv
// Randomized reset/run stimulus against a raster-position reference model of the scanout.
module tb_vga_scan_reader;

  localparam int FRAME = 800 * 525;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        test_mode = 1'b0;
  logic [15:0] addr_b;
  logic [7:0]  q_b;
  logic        vga_hs, vga_vs, vga_blank_n, vblank, frame_start;
  logic [2:0]  vga_r, vga_g;
  logic [1:0]  vga_b;

  int          nvec = 0, nerr = 0;
  int          k = 0;
  bit          started = 1'b0;
  bit          tm = 1'b0;
  logic [15:0] exp_addr = '0;
  int          last_fall = -1;
  logic        prev_hs = 1'b1;

  vga_scan_reader dut (
    .clk(clk), .rst(rst), .addr_b(addr_b), .q_b(q_b),
    .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_blank_n(vga_blank_n), .vblank(vblank), .frame_start(frame_start),
    .test_mode(test_mode)
  );

  always #20 clk = ~clk;

  // Synchronous-read frame buffer whose contents are the low address byte.
  always @(posedge clk) q_b <= addr_b[7:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h (k=%0d)", tag, got, exp, k);
    end
  endtask

  function automatic bit pos_active(input int p);
    return ((p % 800) < 640) && ((p / 800) < 480);
  endfunction

  function automatic int pos_addr(input int p);
    return ((p / 800) / 4) * 160 + (p % 800) / 4;
  endfunction

  // Expected {hs,vs,blank_n,rgb,vblank,frame_start} k clocks after the reset edge.
  function automatic logic [12:0] expect_at(input int kk, input bit tmode);
    int p0, p, h, v, a, bar;
    logic hs, vs, act, vb, fs;
    logic [7:0] px;
    logic [2:0] b3;
    p0 = kk % FRAME;
    vb = (p0 / 800) >= 480;
    fs = (p0 % 800 == 0) && (p0 / 800 == 480);
    if (kk < 3) return {1'b1, 1'b1, 1'b0, 8'h00, vb, fs};
    p   = (kk - 3) % FRAME;
    h   = p % 800;
    v   = p / 800;
    hs  = !(h >= 656 && h <= 751);
    vs  = !(v >= 490 && v <= 491);
    act = pos_active(p);
    a   = pos_addr(p);
    bar = h / 80;
    b3  = bar[2:0];
    px  = tmode ? {b3, b3, b3[2:1]} : a[7:0];
    return {hs, vs, act, act ? px : 8'h00, vb, fs};
  endfunction

  // Raster position tracker: k counts clocks since the last sampled reset.
  always @(posedge clk) begin
    if (rst) begin
      k        <= 0;
      exp_addr <= '0;
      started  <= 1'b1;
    end else begin
      if (started && pos_active(k % FRAME)) exp_addr <= 16'(pos_addr(k % FRAME));
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("outputs", {vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, vblank, frame_start},
          expect_at(k, tm));
      chk("addr_b", addr_b, exp_addr);
      chk("addr_range", addr_b <= 16'd19199, 1'b1);
      if (k == 3) chk("first_px_blank_n", vga_blank_n, 1'b1);
      if (!tm && k == 7)        chk("px_4_0", {vga_r, vga_g, vga_b}, 8'h01);
      if (!tm && k == 3 + 3200) chk("px_0_4", {vga_r, vga_g, vga_b}, 8'hA0);
      if (k < 3) begin
        last_fall = -1;
      end else if (prev_hs && !vga_hs) begin
        if (last_fall >= 0) chk("hs_period", k - last_fall, 800);
        last_fall = k;
      end else if (!prev_hs && vga_hs && last_fall >= 0) begin
        chk("hs_low", k - last_fall, 96);
      end
      prev_hs = vga_hs;
    end
  end

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
`ifdef VGA_SCAN_TESTPAT_EN
      test_mode = tm;
`else
      test_mode = 1'($urandom % 2);
`endif
    end
  endtask

  initial begin
`ifdef VGA_SCAN_TESTPAT_EN
    tm = 1'($urandom % 2);
`endif
    rst = 1'b1;
    run(3);
    rst = 1'b0;
    run(12 * 800 + 50);
    for (int i = 0; i < 4; i++) begin
      run($urandom_range(500, 6000));
      rst = 1'b1;
      run($urandom_range(1, 4));
      rst = 1'b0;
    end
    // Mid-line reset deep into a frame, then let it restart cleanly.
    run(20 * 800 + 300);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(8000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
